// File: rtl/antares_pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// No timing of its own; holds the state encoding and the default reset vector.
// Imported by the sequencer; has no ports.
package antares_pc_sequencer_pkg;

    typedef enum logic {
        PCSEQ_RUN  = 1'b0,
        PCSEQ_PEND = 1'b1
    } pcseq_state_e;

    localparam logic [31:0] PCSEQ_RESET_VECTOR = 32'hBFC0_0000;

    function automatic logic pc_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/antares_pc_sequencer.sv
// Fetch PC owner: arbitrates exception vector, branch target and PC+4 with one delay slot.
// Latency: new if_pc one cycle after branch_accept or after if_stall drops while a redirect is held.
// Backpressure: if_stall freezes if_pc; redirects resolved under stall are held until IF frees.
// Optional: ANTARES_BRANCH_ALIGN_CHECK_EN rejects targets with bits [1:0] set and pulses exc_pc_misaligned.
module antares_pc_sequencer
    import antares_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PCSEQ_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        id_stall,
    input  logic        id_is_cti,
    input  logic        id_take_branch,
    input  logic [31:0] pc_branch_address,
    input  logic        exc_request,
    input  logic [31:0] exc_vector,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_add4,
    output logic        if_in_bds,
    output logic        pc_redirect_pending,
    output logic        exc_pc_misaligned
);

`ifdef ANTARES_BRANCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    pcseq_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_target_q, pend_target_d;
    logic         pend_exc_q, pend_exc_d;
    logic         misaligned_q, misaligned_d;
    logic         branch_accept;
    logic         branch_bad;
    logic         pend_bad;

    assign branch_accept = id_is_cti & id_take_branch & ~id_stall & ~exc_request;
    assign branch_bad    = ALIGN_CHECK & pc_misaligned(pc_branch_address);
    assign pend_bad      = ALIGN_CHECK & pc_misaligned(pend_target_q);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_target_d = pend_target_q;
        pend_exc_d    = pend_exc_q;
        misaligned_d  = 1'b0;
        case (state_q)
            PCSEQ_RUN: begin
                if (exc_request) begin
                    if (!if_stall) begin
                        pc_d = exc_vector;
                    end else begin
                        pend_target_d = exc_vector;
                        pend_exc_d    = 1'b1;
                        state_d       = PCSEQ_PEND;
                    end
                end else if (branch_accept) begin
                    // A rejected target is never parked; the exception unit takes over.
                    if (branch_bad) begin
                        misaligned_d = 1'b1;
                    end else if (!if_stall) begin
                        pc_d = pc_branch_address;
                    end else begin
                        pend_target_d = pc_branch_address;
                        pend_exc_d    = 1'b0;
                        state_d       = PCSEQ_PEND;
                    end
                end else if (!if_stall) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            PCSEQ_PEND: begin
                if (exc_request) begin
                    pend_target_d = exc_vector;
                    pend_exc_d    = 1'b1;
                end
                if (!if_stall) begin
                    state_d = PCSEQ_RUN;
                    if (exc_request) begin
                        pc_d = exc_vector;
                    end else if (pend_bad) begin
                        misaligned_d = 1'b1;
                    end else begin
                        pc_d = pend_target_q;
                    end
                end
            end
            default: state_d = PCSEQ_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= PCSEQ_RUN;
            pc_q          <= RESET_VECTOR;
            pend_target_q <= 32'd0;
            pend_exc_q    <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_target_q <= pend_target_d;
            pend_exc_q    <= pend_exc_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign if_pc               = pc_q;
    assign if_pc_add4          = pc_q + 32'd4;
    assign pc_redirect_pending = (state_q == PCSEQ_PEND);
    assign exc_pc_misaligned   = misaligned_q;
    // While held, the instruction stuck in IF is the delay slot unless an exception owns the redirect.
    assign if_in_bds = (state_q == PCSEQ_PEND) ? (~pend_exc_q & ~exc_request) : branch_accept;

    // The delay slot must reach ID before another CTI can resolve.
    no_branch_in_pend: assert property (@(posedge clk) disable iff (!rst)
        (state_q == PCSEQ_PEND) |-> !branch_accept);

endmodule
